leaf_gpu_ingress_queue: RTL and testbench

//  GPU-side ingress stage for a group leaf router. Buffers GPU packets {dest_addr, data}
//  in a FIFO with a valid/ready handshake and presents them to the router's GPU input

---
 rtl/leaf_gpu_ingress_queue.sv | 192 +++++++++++++++++++
 tb/tb_leaf_gpu_ingress_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_gpu_ingress_queue.sv
`default_nettype none
// ============================================================================
// Module      : leaf_gpu_ingress_queue
// Description : GPU ingress FIFO for a group leaf router. It uses a registered
//               show-ahead head, drops self-addressed packets and reports
//               occupancy and watermark status. The optional statistics
//               counters are enabled by the macro LEAF_INGRESS_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_gpu_ingress_queue #(
    parameter int         DWIDTH     = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter int         ROUTER_ID  = 3,
    parameter logic [3:0] GROUP_ID   = 4'b0110,
    parameter int         AF_LEVEL   = 6,
    localparam int        CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              gpu_valid_i,
    output logic              gpu_ready_o,
    input  logic [DWIDTH-1:0] gpu_data_i,
    input  logic [5:0]        gpu_dest_i,
    output logic              rtr_valid_o,
    input  logic              rtr_ready_i,
    output logic [DWIDTH-1:0] rtr_data_o,
    output logic [5:0]        rtr_dest_o,
    output logic [CW-1:0]     count_o,
    output logic              almost_full_o,
    output logic              self_drop_o
`ifdef LEAF_INGRESS_STATS_EN
    ,
    output logic [15:0]       pkt_in_cnt_o,
    output logic [15:0]       pkt_out_cnt_o,
    output logic [15:0]       drop_cnt_o
`endif
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam int              EW         = DWIDTH + 6;
    localparam logic [5:0]      LOCAL_ADDR = {GROUP_ID, 2'(ROUTER_ID)};
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]   CNT_FULL   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   CNT_AF     = CW'(AF_LEVEL);

    localparam logic [0:0]      ST_EMPTY   = 1'b0;
    localparam logic [0:0]      ST_HOLD    = 1'b1;

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [0:0]        state_q, state_d;
    logic [EW-1:0]     head_d;
    logic [DWIDTH-1:0] rtr_data_q;
    logic [5:0]        rtr_dest_q;
    logic              self_drop_q;

    logic              w_full;
    logic              w_hs;
    logic              w_self;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic [AW-1:0]     w_rd_next;
    logic [EW-1:0]     w_in_entry;

    // Ready is forced low while reset is held and during a flush cycle.
    assign w_full      = (count_q == CNT_FULL);
    assign gpu_ready_o = rst_ni && !w_full && !flush_i;

    assign w_hs       = gpu_valid_i && gpu_ready_o;
    assign w_self     = (gpu_dest_i == LOCAL_ADDR);
    assign w_push     = w_hs && !w_self && !w_full;
    assign w_drop     = w_hs && w_self;
    assign w_pop      = (state_q == ST_HOLD) && rtr_ready_i && !flush_i && (count_q != '0);
    assign w_rd_next  = rd_ptr_q + AW'(1);
    assign w_in_entry = {gpu_dest_i, gpu_data_i};

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = {rtr_dest_q, rtr_data_q};
        if (flush_i) begin
            state_d  = ST_EMPTY;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // The head register always mirrors the oldest stored entry; when
            // the last entry leaves alongside a push, the new packet bypasses
            // memory so it shows up without a bubble.
            case (state_q)
                ST_EMPTY: begin
                    if (w_push) begin
                        state_d = ST_HOLD;
                        head_d  = w_in_entry;
                    end
                end
                ST_HOLD: begin
                    if (w_pop) begin
                        if (count_q != CNT_ONE) begin
                            head_d = mem_q[w_rd_next];
                        end else if (w_push) begin
                            head_d = w_in_entry;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_in_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rtr_data_q  <= '0;
            rtr_dest_q  <= '0;
            self_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            {rtr_dest_q, rtr_data_q} <= head_d;
            self_drop_q <= w_drop;
        end
    end

    assign rtr_valid_o   = (state_q == ST_HOLD);
    assign rtr_data_o    = rtr_data_q;
    assign rtr_dest_o    = rtr_dest_q;
    assign count_o       = count_q;
    assign almost_full_o = (count_q >= CNT_AF);
    assign self_drop_o   = self_drop_q;

`ifdef LEAF_INGRESS_STATS_EN
    logic [15:0] pkt_in_cnt_q;
    logic [15:0] pkt_out_cnt_q;
    logic [15:0] drop_cnt_q;

    // Saturating event counters; flush deliberately leaves them untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_in_cnt_q  <= '0;
            pkt_out_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            if (w_push && (pkt_in_cnt_q != 16'hFFFF)) begin
                pkt_in_cnt_q <= pkt_in_cnt_q + 16'd1;
            end
            if (w_pop && (pkt_out_cnt_q != 16'hFFFF)) begin
                pkt_out_cnt_q <= pkt_out_cnt_q + 16'd1;
            end
            if (self_drop_q && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_in_cnt_o  = pkt_in_cnt_q;
    assign pkt_out_cnt_o = pkt_out_cnt_q;
    assign drop_cnt_o    = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_leaf_gpu_ingress_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_leaf_gpu_ingress_queue
// Description : Scoreboard bench for leaf_gpu_ingress_queue. It runs directed
//               scenarios followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_gpu_ingress_queue;

    localparam int         DW        = 16;
    localparam int         DEPTH     = 8;
    localparam int         AF        = 6;
    localparam int         CW        = $clog2(DEPTH + 1);
    localparam logic [5:0] SELF_ADDR = 6'b011011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          gpu_valid;
    logic          gpu_ready;
    logic [DW-1:0] gpu_data;
    logic [5:0]    gpu_dest;
    logic          rtr_valid;
    logic          rtr_ready;
    logic [DW-1:0] rtr_data;
    logic [5:0]    rtr_dest;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          self_drop;
`ifdef LEAF_INGRESS_STATS_EN
    logic [15:0]   pkt_in_cnt;
    logic [15:0]   pkt_out_cnt;
    logic [15:0]   drop_cnt;
`endif

    always #5 clk = ~clk;

    leaf_gpu_ingress_queue dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .gpu_valid_i   (gpu_valid),
        .gpu_ready_o   (gpu_ready),
        .gpu_data_i    (gpu_data),
        .gpu_dest_i    (gpu_dest),
        .rtr_valid_o   (rtr_valid),
        .rtr_ready_i   (rtr_ready),
        .rtr_data_o    (rtr_data),
        .rtr_dest_o    (rtr_dest),
        .count_o       (count),
        .almost_full_o (almost_full),
        .self_drop_o   (self_drop)
`ifdef LEAF_INGRESS_STATS_EN
        ,
        .pkt_in_cnt_o  (pkt_in_cnt),
        .pkt_out_cnt_o (pkt_out_cnt),
        .drop_cnt_o    (drop_cnt)
`endif
    );

    // Reference model: an ordered list of {dest, data} the queue should hold.
    logic [DW+5:0] exp_q[$];
    logic          exp_drop  = 1'b0;
    logic          mon_en    = 1'b0;
    int            n_cmp     = 0;
    int            n_bad     = 0;
    int            exp_in    = 0;
    int            exp_out   = 0;
    int            exp_drops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus: called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic gv, input logic [DW-1:0] d, input logic [5:0] dst,
                        input logic rr, input logic fl);
        logic hs;
        gpu_valid = gv;
        gpu_data  = d;
        gpu_dest  = dst;
        rtr_ready = rr;
        flush     = fl;
        @(negedge clk);
        hs = gpu_valid && gpu_ready;
        @(posedge clk);
        #1;
        exp_drop = hs && (dst == SELF_ADDR);
        if (hs && (dst == SELF_ADDR)) exp_drops++;
        if (hs && (dst != SELF_ADDR)) begin
            exp_q.push_back({dst, d});
            exp_in++;
        end
    endtask

    task automatic idle(input logic rr, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 6'd0, rr, 1'b0);
    endtask

    // Monitor: compares status each cycle and pops the model on every handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [DW+5:0] e;
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("rtr_valid", 32'(rtr_valid), 32'(exp_q.size() != 0));
            chk("gpu_ready", 32'(gpu_ready), 32'((exp_q.size() < DEPTH) && !flush));
            chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AF));
            chk("self_drop", 32'(self_drop), 32'(exp_drop));
            if (flush) begin
                exp_q.delete();
            end else if (rtr_valid && rtr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_on_empty_model", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    exp_out++;
                    chk("rtr_data", 32'(rtr_data), 32'(e[DW-1:0]));
                    chk("rtr_dest", 32'(rtr_dest), 32'(e[DW+5:DW]));
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rtr_valid"}, 32'(rtr_valid), 32'(0));
        chk({tag, "_rtr_data"}, 32'(rtr_data), 32'(0));
        chk({tag, "_rtr_dest"}, 32'(rtr_dest), 32'(0));
        chk({tag, "_count"}, 32'(count), 32'(0));
        chk({tag, "_gpu_ready"}, 32'(gpu_ready), 32'(0));
        chk({tag, "_almost_full"}, 32'(almost_full), 32'(0));
        chk({tag, "_self_drop"}, 32'(self_drop), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rr_pct;
        logic [5:0] dst;
        rst_n     = 1'b0;
        flush     = 1'b0;
        gpu_valid = 1'b0;
        gpu_data  = '0;
        gpu_dest  = '0;
        rtr_ready = 1'b0;
        #2;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single packet: it should be presented one cycle later and then leave.
        step(1'b1, 16'h1234, 6'b000101, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Fill to full while the router stalls, then attempt one more push.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(16'hA000 + i), 6'b000001, 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 6'b000010, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'(DEPTH));
        idle(1'b1, DEPTH + 1);

        // Self-addressed packet is swallowed.
        step(1'b1, 16'hABCD, SELF_ADDR, 1'b0, 1'b0);
        idle(1'b0, 2);

        // Steady push+pop at count 4 long enough to wrap pointers twice.
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'hB000 + i), 6'b100000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 16'(16'hC000 + i), 6'b010101, 1'b1, 1'b0);
        chk("steady_count", 32'(count), 32'(4));

        // Flush with a concurrent push at count 5.
        step(1'b1, 16'hC100, 6'b010101, 1'b0, 1'b0);
        step(1'b1, 16'hEEEE, 6'b000011, 1'b0, 1'b1);
        idle(1'b0, 1);
        chk("post_flush_count", 32'(count), 32'(0));

        // Asynchronous reset while a head packet is held.
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'hD000 + i), 6'b111000, 1'b0, 1'b0);
        idle(1'b0, 1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_q.delete();
        exp_drop  = 1'b0;
        exp_in    = 0;
        exp_out   = 0;
        exp_drops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(1'b1, 16'h5A5A, 6'b000001, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Randomized traffic with varying router back-pressure.
        for (int seg = 0; seg < 4; seg++) begin
            rr_pct = (seg == 0) ? 90 : (seg == 1) ? 50 : (seg == 2) ? 15 : 70;
            for (int i = 0; i < 500; i++) begin
                dst = ($urandom_range(0, 7) == 0) ? SELF_ADDR : 6'($urandom);
                step($urandom_range(0, 99) < 70, 16'($urandom), dst,
                     $urandom_range(0, 99) < rr_pct, $urandom_range(0, 99) < 2);
            end
        end

        idle(1'b1, DEPTH + 2);
        chk("drain_count", 32'(count), 32'(0));
`ifdef LEAF_INGRESS_STATS_EN
        chk("pkt_in_cnt", 32'(pkt_in_cnt), 32'(exp_in));
        chk("pkt_out_cnt", 32'(pkt_out_cnt), 32'(exp_out));
        chk("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
`endif
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
